// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the data bus arbiter: FSM state encoding, access size codes
// and master indices.
package data_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic M_CORE   = 1'b0;
  localparam logic M_LOADER = 1'b1;

endpackage

// File: rtl/data_bus_arbiter_pick.sv
// bus_arb_pick: combinational winner select between the two masters.
// RISCUIN_ARB_ROUND_ROBIN_EN selects round-robin; otherwise m0 has fixed priority.
module bus_arb_pick
  import data_bus_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  input  logic owner,
  input  logic done_now,
  output logic any_req,
  output logic winner,
  output logic ptr_next
);

  // Winner select and next round-robin pointer
  always_comb begin
    any_req = req0 | req1;
`ifdef RISCUIN_ARB_ROUND_ROBIN_EN
    if (req0 && req1) begin
      winner = ptr;
    end else if (req1) begin
      winner = M_LOADER;
    end else begin
      winner = M_CORE;
    end
    // Favour the master that did not own the transaction just completed
    if (done_now) begin
      ptr_next = ~owner;
    end else begin
      ptr_next = ptr;
    end
`else
    if (req0) begin
      winner = M_CORE;
    end else if (req1) begin
      winner = M_LOADER;
    end else begin
      winner = M_CORE;
    end
    ptr_next = 1'b0;
`endif
  end

`ifndef RISCUIN_ARB_ROUND_ROBIN_EN
  logic unused_rr;
  assign unused_rr = ptr ^ owner ^ done_now;
`endif

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master data bus arbiter and transaction sequencer (IDLE/ISSUE/WAIT/DONE).
// Arbitration policy is set by RISCUIN_ARB_ROUND_ROBIN_EN inside bus_arb_pick.
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [1:0]            m0_size,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [1:0]            m1_size,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m0_gnt,
  output logic                  m1_gnt,
  output logic                  m0_done,
  output logic                  m1_done,
  output logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  s_wr,
  output logic                  s_rd,
  output logic [1:0]            s_size,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_wdata,
  input  logic                  s_ready,
  input  logic                  s_busy,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  output logic                  arb_busy
);

  arb_state_t state, state_nx;
  logic owner, we_l, ptr;
  logic any_req, winner, ptr_next, win_we;
  logic gnt0_nx, gnt1_nx, done0_nx, done1_nx, wr_nx, rd_nx;
  logic latch, capture;

  bus_arb_pick u_pick (
    .req0     (m0_req),
    .req1     (m1_req),
    .ptr      (ptr),
    .owner    (owner),
    .done_now (state == DONE),
    .any_req  (any_req),
    .winner   (winner),
    .ptr_next (ptr_next)
  );

  assign win_we = winner ? m1_we : m0_we;

  // Next state plus next values of the registered outputs
  always_comb begin
    state_nx = state;
    gnt0_nx  = m0_gnt;
    gnt1_nx  = m1_gnt;
    done0_nx = 1'b0;
    done1_nx = 1'b0;
    wr_nx    = 1'b0;
    rd_nx    = 1'b0;
    latch    = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req && s_ready) begin
          state_nx = ISSUE;
          latch    = 1'b1;
          gnt0_nx  = (winner == M_CORE);
          gnt1_nx  = (winner == M_LOADER);
          wr_nx    = win_we;
          rd_nx    = ~win_we;
        end else begin
          gnt0_nx = 1'b0;
          gnt1_nx = 1'b0;
        end
      end
      ISSUE: begin
        state_nx = WAIT;
      end
      WAIT: begin
        if (s_busy || !s_ready) begin
          state_nx = WAIT;
        end else begin
          state_nx = DONE;
          capture  = ~we_l;
          done0_nx = (owner == M_CORE);
          done1_nx = (owner == M_LOADER);
        end
      end
      DONE: begin
        state_nx = IDLE;
        gnt0_nx  = 1'b0;
        gnt1_nx  = 1'b0;
      end
      default: begin
        state_nx = IDLE;
        gnt0_nx  = 1'b0;
        gnt1_nx  = 1'b0;
      end
    endcase
  end

  // State, command latch, read data capture and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= M_CORE;
      we_l     <= 1'b0;
      ptr      <= 1'b0;
      m0_gnt   <= 1'b0;
      m1_gnt   <= 1'b0;
      m0_done  <= 1'b0;
      m1_done  <= 1'b0;
      s_wr     <= 1'b0;
      s_rd     <= 1'b0;
      arb_busy <= 1'b0;
      s_size   <= SIZE_BYTE;
      s_addr   <= {ADDR_WIDTH{1'b0}};
      s_wdata  <= {DATA_WIDTH{1'b0}};
      m_rdata  <= {DATA_WIDTH{1'b0}};
    end else begin
      state    <= state_nx;
      ptr      <= ptr_next;
      m0_gnt   <= gnt0_nx;
      m1_gnt   <= gnt1_nx;
      m0_done  <= done0_nx;
      m1_done  <= done1_nx;
      s_wr     <= wr_nx;
      s_rd     <= rd_nx;
      arb_busy <= (state_nx != IDLE);
      if (latch) begin
        owner   <= winner;
        we_l    <= win_we;
        s_size  <= winner ? m1_size  : m0_size;
        s_addr  <= winner ? m1_addr  : m0_addr;
        s_wdata <= winner ? m1_wdata : m0_wdata;
      end
      if (capture) begin
        m_rdata <= s_rdata;
      end
    end
  end

endmodule
